// File: rtl/serial_tx_frame_pkg.sv
`default_nettype none
// =============================================================================
// Module   : serial_tx_frame_pkg
// Brief    : Shared state encodings and line constants for the serial link.
// Revision : 1.0
// =============================================================================
package serial_tx_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic c_LINE_IDLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bit_period_counter.sv
`default_nettype none
// =============================================================================
// Module   : bit_period_counter
// Brief    : Counts clk cycles within one serial bit and strobes the last one.
// Revision : 1.0
// =============================================================================
module bit_period_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [c_CNT_W-1:0] r_cnt;

   assign bit_end = (r_cnt == c_CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clear || bit_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_tx_frame.sv
`default_nettype none
// =============================================================================
// Module   : serial_tx_frame
// Brief    : Valid/ready word in, start + LSB-first data + opt. parity + stop out.
// Revision : 1.0
// =============================================================================
module serial_tx_frame
   import serial_tx_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   tx_state_t          r_state, w_state_nx;
   logic [DATA_W-1:0]  r_shift, w_shift_nx;
   logic [c_BIT_W-1:0] r_bit,   w_bit_nx;
   logic               r_par,   w_par_nx;
   logic               w_tx_nx, w_done_nx;
   logic               w_bit_end;

   // Held cleared while idle so the start bit always gets a full period.
   bit_period_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_period_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (r_state == ST_IDLE),
      .bit_end (w_bit_end)
   );

   always_comb begin
      w_state_nx = r_state;
      w_shift_nx = r_shift;
      w_bit_nx   = r_bit;
      w_par_nx   = r_par;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (valid) begin
               w_shift_nx = data_in;
               w_par_nx   = ^data_in;
               w_bit_nx   = '0;
               w_state_nx = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_end) w_state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_nx = r_shift >> 1;
               if (r_bit == c_BIT_W'(DATA_W - 1)) begin
                  w_bit_nx   = '0;
                  w_state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  w_bit_nx = r_bit + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) w_state_nx = ST_STOP;
         end
         ST_STOP: begin
            if (w_bit_end) begin
               w_state_nx = ST_IDLE;
               w_done_nx  = 1'b1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // Line level is decoded from the next state so every output is a flop.
      w_tx_nx = c_LINE_IDLE;
      case (w_state_nx)
         ST_START:  w_tx_nx = 1'b0;
         ST_DATA:   w_tx_nx = w_shift_nx[0];
         ST_PARITY: w_tx_nx = w_par_nx;
         default:   w_tx_nx = c_LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_par   <= 1'b0;
         tx      <= c_LINE_IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_shift <= w_shift_nx;
         r_bit   <= w_bit_nx;
         r_par   <= w_par_nx;
         tx      <= w_tx_nx;
         ready   <= (w_state_nx == ST_IDLE);
         busy    <= (w_state_nx != ST_IDLE);
         done    <= w_done_nx;
      end
   end

endmodule
`default_nettype wire
